// File: rtl/fft_stream_tx.sv
// fft_stream_tx: frames a free-running complex sample stream into 2^LOGS_FFT_LEN-sample
// AXI4-Stream frames, each preceded by a one-cycle config beat, through an elastic FIFO.
module fft_stream_tx #(
   parameter int LOGS_FFT_LEN = 13,
   parameter int INPUT_WIDTH  = 11,
   parameter int DATAIN_WIDTH = 16,
   parameter int FIFO_AW      = 4
) (
   input  logic                      i_aclk,
   input  logic                      i_aresetn,
   input  logic                      i_start,
   input  logic                      i_continuous,
   input  logic                      i_fft_mode,
   input  logic                      i_sample_vld,
   input  logic [INPUT_WIDTH-1:0]    i_sample_re,
   input  logic [INPUT_WIDTH-1:0]    i_sample_im,
   input  logic                      i_ovf_clr,
   output logic                      o_axi4s_cfg_tvalid,
   output logic                      o_axi4s_cfg_tdata,
   output logic                      o_axi4s_data_tvalid,
   output logic [2*DATAIN_WIDTH-1:0] o_axi4s_data_tdata,
   output logic                      o_axi4s_data_tlast,
   input  logic                      i_axi4s_data_tready,
   output logic                      o_busy,
   output logic                      o_overflow,
   output logic [15:0]               o_frame_cnt
);
   localparam int DEPTH = 1 << FIFO_AW;
   localparam int SW    = 2 * INPUT_WIDTH;
   typedef enum logic [1:0] {IDLE, CFG, STREAM, DONE} state_t;
   state_t                  state_q, state_d;
   logic                    mode_q, mode_d;
   logic [LOGS_FFT_LEN:0]   in_cnt_q, in_cnt_d;
   logic [LOGS_FFT_LEN-1:0] out_cnt_q, out_cnt_d;
   logic [FIFO_AW:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic                    ovf_q, ovf_d;
   logic [15:0]             frame_cnt_q, frame_cnt_d;
   logic [SW-1:0]           mem_q [DEPTH];
   logic                    empty, full, rd_en, in_win, wr_en, drop;
   logic [SW-1:0]           rd_word;
   always_comb begin
      empty       = wr_ptr_q == rd_ptr_q;
      full        = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                    (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
      rd_en       = !empty && i_axi4s_data_tready;
      // in_cnt saturates at N, so its MSB marks the end of the acceptance window
      in_win      = state_q == STREAM && !in_cnt_q[LOGS_FFT_LEN] && i_sample_vld;
      wr_en       = in_win && (!full || rd_en);
      drop        = in_win && full && !rd_en;
      wr_ptr_d    = wr_ptr_q + (FIFO_AW+1)'(wr_en);
      rd_ptr_d    = rd_ptr_q + (FIFO_AW+1)'(rd_en);
      in_cnt_d    = state_q == CFG ? '0 : in_cnt_q + (LOGS_FFT_LEN+1)'(wr_en);
      out_cnt_d   = state_q == CFG ? '0 : out_cnt_q + LOGS_FFT_LEN'(rd_en);
      ovf_d       = drop || (ovf_q && !i_ovf_clr);
      frame_cnt_d = frame_cnt_q + 16'(state_q == DONE);
      mode_d      = ((state_q == IDLE && i_start) || (state_q == DONE && i_continuous)) ?
                    i_fft_mode : mode_q;
      state_d     = state_q == IDLE   ? (i_start ? CFG : IDLE) :
                    state_q == CFG    ? STREAM :
                    state_q == STREAM ? ((rd_en && &out_cnt_q) ? DONE : STREAM) :
                    (i_continuous ? CFG : IDLE);
      rd_word     = mem_q[rd_ptr_q[FIFO_AW-1:0]];
   end
   always_ff @(posedge i_aclk) begin
      if (!i_aresetn) begin
         state_q     <= IDLE;
         mode_q      <= 1'b0;
         in_cnt_q    <= '0;
         out_cnt_q   <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         ovf_q       <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         in_cnt_q    <= in_cnt_d;
         out_cnt_q   <= out_cnt_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         ovf_q       <= ovf_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end
   always_ff @(posedge i_aclk) begin
      if (wr_en) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= {i_sample_im, i_sample_re};
   end
   assign o_axi4s_cfg_tvalid  = state_q == CFG;
   assign o_axi4s_cfg_tdata   = state_q == CFG && mode_q;
   assign o_axi4s_data_tvalid = !empty;
   assign o_axi4s_data_tdata  = empty ? '0 :
                                {DATAIN_WIDTH'($signed(rd_word[SW-1:INPUT_WIDTH])),
                                 DATAIN_WIDTH'($signed(rd_word[INPUT_WIDTH-1:0]))};
   assign o_axi4s_data_tlast  = !empty && &out_cnt_q;
   assign o_busy              = state_q != IDLE || !empty;
   assign o_overflow          = ovf_q;
   assign o_frame_cnt         = frame_cnt_q;
endmodule

// File: doc/fft_stream_tx.md
Name: fft_stream_tx

Overview:
- AXI4-Stream frame transmitter that feeds the pipeline FFT wrapper's data and config inputs.
- Collects a free-running complex sample stream (ADC/DDC side) into exactly 2^LOGS_FFT_LEN-sample frames.
- Before each frame it issues a one-cycle config beat, then streams the frame with tlast on the final sample.
- Honours tready through a small elastic FIFO and flags dropped samples.

Parameters:
- LOGS_FFT_LEN, 13, log2 of the frame length N.
- INPUT_WIDTH, 11, signed sample width per component.
- DATAIN_WIDTH, 16, byte-padded lane width per component; must be ≥ INPUT_WIDTH.
- FIFO_AW, 4, log2 of the elastic FIFO depth.

Ports:
- i_aclk  in  1  clock.
- i_aresetn  in  1  synchronous active-low reset.
- i_start  in  1  arm one frame (pulse).
- i_continuous  in  1  re-arm automatically after each frame.
- i_fft_mode  in  1  1 = forward, 0 = inverse; sampled at arm.
- i_sample_vld  in  1  sample strobe.
- i_sample_re  in  INPUT_WIDTH  signed real.
- i_sample_im  in  INPUT_WIDTH  signed imaginary.
- i_ovf_clr  in  1  clear sticky overflow.
- o_axi4s_cfg_tvalid  out  1  config beat.
- o_axi4s_cfg_tdata  out  1  latched fft_mode.
- o_axi4s_data_tvalid  out  1  data valid.
- o_axi4s_data_tdata  out  2*DATAIN_WIDTH  packed as {sext(im), sext(re)}.
- o_axi4s_data_tlast  out  1  last sample of frame.
- i_axi4s_data_tready  in  1  downstream ready.
- o_busy  out  1  state != IDLE or FIFO non-empty.
- o_overflow  out  1  sticky: a sample was dropped.
- o_frame_cnt  out  16  completed frames, wraps at 0xFFFF->0.

Behaviour:
- Reset (i_aresetn=0 at a clock edge):
  - All outputs 0; FSM to IDLE; FIFO emptied; counters cleared.
  - Applies mid-frame too: the frame is abandoned and no tlast is emitted.
- FSM states:
  - IDLE: on i_start=1 latch i_fft_mode, go to CFG.
  - CFG: exactly one cycle with cfg_tvalid=1 and cfg_tdata=latched mode (no ready on the config channel). Next state STREAM.
  - STREAM: accept samples, in_cnt 0..N-1. When the out_cnt=N-1 beat handshakes (tvalid&tready), go to DONE.
  - DONE: one cycle; o_frame_cnt+1. Then go to CFG if i_continuous=1, else IDLE.
- i_start outside IDLE is ignored.
- Sample acceptance is in STREAM only, while in_cnt<N. Samples in IDLE/CFG/DONE, or after N are accepted, are discarded silently (no overflow).
- Sample with i_sample_vld=1, in window, FIFO full: dropped, in_cnt not incremented, o_overflow set.
- Overflow set and i_ovf_clr in the same cycle: set wins.
- Packing: tdata[DATAIN_WIDTH-1:0]=sign-extended re; tdata[2*DATAIN_WIDTH-1:DATAIN_WIDTH]=sign-extended im.
- Latency: a sample written at edge t may appear on tdata at t+1 at the earliest. Simultaneous FIFO write and read when full is allowed: the read frees the slot, so no drop.
- AXI rules:
  - Once tvalid=1, tdata/tlast hold stable until tready=1.
  - tvalid never depends combinationally on tready.
  - tlast=1 only on the beat with out_cnt=N-1.
- out_cnt increments per handshake and wraps to 0 after N-1.
- FIFO may never hold samples of two frames: in_cnt caps at N per frame.
- o_frame_cnt wraps 0xFFFF->0.

Test Plan:
- N=8 (LOGS_FFT_LEN=3), i_start pulse, mode=1, tready=1, samples re=k, im=-k for k=0..9 → one cfg beat tdata=1 followed by exactly 8 data beats; beat k tdata={16'(-k),16'(k)}; tlast only on k=7; samples 8,9 discarded; o_frame_cnt=1; o_overflow=0.
- Same with tready toggling 1010…, sample every 2nd cycle → 8 beats, payload stable across every stall, no overflow.
- tready=0 held, 20 consecutive samples, FIFO_AW=2 → 4 stored, o_overflow=1; release tready → 4 beats emitted, no tlast, FSM stays STREAM until 4 more samples arrive; i_ovf_clr clears flag.
- i_continuous=1 → cfg beat precedes each frame; 3 frames gives o_frame_cnt=3; i_start pulses during STREAM are ignored.
- Reset asserted after beat 4 of a frame → next cycle all outputs 0 and o_busy=0; a fresh i_start gives a cfg beat and a full 8-beat frame from index 0.
- Overflow set and i_ovf_clr in the same cycle → o_overflow=1.
